// File: rtl/wt_dcache_shct_predictor_if.sv
// rtl/wt_dcache_shct_predictor_if.sv - SHCT lookup and train port bundle
interface wt_dcache_shct_predictor_if #(
    parameter int SIG_WIDTH = 14,
    parameter int CTR_WIDTH = 2
);
    logic                 lookup_req_i;
    logic [SIG_WIDTH-1:0] lookup_sig_i;
    logic                 lookup_valid_o;
    logic [CTR_WIDTH-1:0] lookup_ctr_o;
    logic                 lookup_reuse_o;
    logic                 hit_i;
    logic [SIG_WIDTH-1:0] hit_sig_i;
    logic                 evict_i;
    logic [SIG_WIDTH-1:0] evict_sig_i;
    logic                 evict_reused_i;

    modport master (
        output lookup_req_i, lookup_sig_i, hit_i, hit_sig_i,
               evict_i, evict_sig_i, evict_reused_i,
        input  lookup_valid_o, lookup_ctr_o, lookup_reuse_o
    );

    modport slave (
        input  lookup_req_i, lookup_sig_i, hit_i, hit_sig_i,
               evict_i, evict_sig_i, evict_reused_i,
        output lookup_valid_o, lookup_ctr_o, lookup_reuse_o
    );
endinterface

// File: rtl/wt_dcache_shct_predictor.sv
// rtl/wt_dcache_shct_predictor.sv - SHiP signature history counter table with chunked init/flush sweep
// Optional performance counters: define WT_DCACHE_SHCT_PERF_CNT_EN.
module wt_dcache_shct_predictor #(
    parameter int SIG_WIDTH       = 14,
    parameter int CTR_WIDTH       = 2,
    parameter int INIT_VAL        = (1 << CTR_WIDTH) - 1,
    parameter int SWEEP_PER_CYCLE = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    output logic                           ready_o,
    wt_dcache_shct_predictor_if.slave      shct,
    output logic [31:0]                    perf_lookup_o,
    output logic [31:0]                    perf_distant_o
);
    localparam int DEPTH  = 1 << SIG_WIDTH;
    localparam int NCHUNK = DEPTH / SWEEP_PER_CYCLE;
    localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(NCHUNK - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] INIT_CTR = CTR_WIDTH'(INIT_VAL);
    localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);

    typedef enum logic [1:0] {S_INIT, S_READY, S_FLUSH} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               sweep_wr;
    logic               ready_q;

    logic [CTR_WIDTH-1:0] tbl [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= (state_d == S_READY);
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sweep_wr = 1'b0;
        case (state_q)
            S_READY: begin
                if (flush_i) begin
                    state_d = S_FLUSH;
                    ptr_d   = '0;
                end
            end
            default: begin
                // A flush while sweeping restarts from chunk 0 without writing.
                if (flush_i) begin
                    ptr_d = '0;
                end else begin
                    sweep_wr = 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        state_d = S_READY;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
        endcase
    end

    assign ready_o = ready_q;

    logic                 active, lk_acc, hit_en, dec_en, cancel;
    logic [CTR_WIDTH-1:0] rd_ctr, hit_cur, ev_cur;

    assign active  = ready_q & ~flush_i;
    assign lk_acc  = active & shct.lookup_req_i;
    assign hit_en  = active & shct.hit_i;
    assign dec_en  = active & shct.evict_i & ~shct.evict_reused_i;
    assign cancel  = hit_en & dec_en & (shct.hit_sig_i == shct.evict_sig_i);
    assign rd_ctr  = tbl[shct.lookup_sig_i];
    assign hit_cur = tbl[shct.hit_sig_i];
    assign ev_cur  = tbl[shct.evict_sig_i];

    // Table has no reset; the sweep is the only initialiser. Sweep and training never overlap.
    always_ff @(posedge clk_i) begin
        if (sweep_wr) begin
            for (int i = 0; i < SWEEP_PER_CYCLE; i++) begin
                tbl[SIG_WIDTH'(int'(ptr_q) * SWEEP_PER_CYCLE + i)] <= INIT_CTR;
            end
        end else if (!cancel) begin
            if (hit_en && hit_cur != CTR_MAX) begin
                tbl[shct.hit_sig_i] <= hit_cur + CTR_ONE;
            end
            if (dec_en && ev_cur != '0) begin
                tbl[shct.evict_sig_i] <= ev_cur - CTR_ONE;
            end
        end
    end

    logic                 valid_q, reuse_q;
    logic [CTR_WIDTH-1:0] ctr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ctr_q   <= '0;
            reuse_q <= 1'b0;
        end else begin
            valid_q <= lk_acc;
            if (lk_acc) begin
                ctr_q   <= rd_ctr;
                reuse_q <= (rd_ctr != '0);
            end
        end
    end

    assign shct.lookup_valid_o = valid_q;
    assign shct.lookup_ctr_o   = ctr_q;
    assign shct.lookup_reuse_o = reuse_q;

`ifdef WT_DCACHE_SHCT_PERF_CNT_EN
    logic [31:0] perf_lookup_q, perf_distant_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_lookup_q  <= '0;
            perf_distant_q <= '0;
        end else if (flush_i) begin
            perf_lookup_q  <= '0;
            perf_distant_q <= '0;
        end else if (lk_acc) begin
            if (perf_lookup_q != '1) perf_lookup_q <= perf_lookup_q + 32'd1;
            if (rd_ctr == '0 && perf_distant_q != '1) perf_distant_q <= perf_distant_q + 32'd1;
        end
    end

    assign perf_lookup_o  = perf_lookup_q;
    assign perf_distant_o = perf_distant_q;
`else
    assign perf_lookup_o  = '0;
    assign perf_distant_o = '0;
`endif
endmodule

// File: tb/tb_wt_dcache_shct_predictor.sv
// tb/tb_wt_dcache_shct_predictor.sv - self-checking bench for wt_dcache_shct_predictor
module tb_wt_dcache_shct_predictor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ready;
    logic [31:0] perf_lookup, perf_distant;

    wt_dcache_shct_predictor_if #(.SIG_WIDTH(14), .CTR_WIDTH(2)) shct_if ();

    wt_dcache_shct_predictor dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .ready_o        (ready),
        .shct           (shct_if.slave),
        .perf_lookup_o  (perf_lookup),
        .perf_distant_o (perf_distant)
    );

    always #5 clk = ~clk;

    typedef enum int {OP_LOOKUP, OP_HIT, OP_EVICT, OP_BOTH, OP_LKHIT} op_e;
    typedef struct {
        op_e         op;
        logic [13:0] sig_a;
        logic [13:0] sig_b;
        logic        reused;
        logic [1:0]  exp_ctr;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_q[$];
    logic       expect_valid = 1'b0;
    logic [1:0] last_exp = 2'd0;
    vec_t       vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        shct_if.lookup_req_i   = 1'b0;
        shct_if.hit_i          = 1'b0;
        shct_if.evict_i        = 1'b0;
        shct_if.evict_reused_i = 1'b0;
    endtask

    // One clock; any lookup result produced at that edge is popped from the scoreboard.
    task automatic tick();
        logic [1:0] e;
        @(posedge clk);
        #1;
        if (shct_if.lookup_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("lookup_ctr", 32'(shct_if.lookup_ctr_o), 32'(e));
                check("lookup_reuse", 32'(shct_if.lookup_reuse_o), 32'(e != 2'd0));
            end
        end else if (expect_valid) begin
            check("lookup_valid", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        expect_valid = 1'b0;
    endtask

    task automatic lookup(input logic [13:0] sig, input logic [1:0] exp);
        shct_if.lookup_req_i = 1'b1;
        shct_if.lookup_sig_i = sig;
        exp_q.push_back(exp);
        expect_valid = 1'b1;
        last_exp = exp;
    endtask

    task automatic evict(input logic [13:0] sig, input logic reused);
        shct_if.evict_i        = 1'b1;
        shct_if.evict_sig_i    = sig;
        shct_if.evict_reused_i = reused;
    endtask

    task automatic hit(input logic [13:0] sig);
        shct_if.hit_i     = 1'b1;
        shct_if.hit_sig_i = sig;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic add(input op_e op, input logic [13:0] a, input logic [13:0] b,
                       input logic r, input logic [1:0] e);
        vec_t v;
        v.op = op; v.sig_a = a; v.sig_b = b; v.reused = r; v.exp_ctr = e;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        idle();
        shct_if.lookup_sig_i = '0;
        shct_if.hit_sig_i    = '0;
        shct_if.evict_sig_i  = '0;

        add(OP_LOOKUP, 14'h0001, 14'h0, 1'b0, 2'd3);
        add(OP_LOOKUP, 14'h3FFF, 14'h0, 1'b0, 2'd3);
        add(OP_EVICT,  14'h0055, 14'h0, 1'b0, 2'd0);
        add(OP_EVICT,  14'h0055, 14'h0, 1'b0, 2'd0);
        add(OP_EVICT,  14'h0055, 14'h0, 1'b0, 2'd0);
        add(OP_LOOKUP, 14'h0055, 14'h0, 1'b0, 2'd0);
        add(OP_EVICT,  14'h0055, 14'h0, 1'b0, 2'd0);
        add(OP_LOOKUP, 14'h0055, 14'h0, 1'b0, 2'd0);
        add(OP_HIT,    14'h1234, 14'h0, 1'b0, 2'd0);
        add(OP_LOOKUP, 14'h1234, 14'h0, 1'b0, 2'd3);
        add(OP_EVICT,  14'h1234, 14'h0, 1'b0, 2'd0);
        add(OP_LOOKUP, 14'h1234, 14'h0, 1'b0, 2'd2);
        add(OP_HIT,    14'h1234, 14'h0, 1'b0, 2'd0);
        add(OP_LOOKUP, 14'h1234, 14'h0, 1'b0, 2'd3);
        add(OP_EVICT,  14'h1234, 14'h0, 1'b1, 2'd0);
        add(OP_LOOKUP, 14'h1234, 14'h0, 1'b0, 2'd3);
        add(OP_EVICT,  14'h0ABC, 14'h0, 1'b0, 2'd0);
        add(OP_BOTH,   14'h0ABC, 14'h0ABC, 1'b0, 2'd0);
        add(OP_LOOKUP, 14'h0ABC, 14'h0, 1'b0, 2'd2);
        add(OP_BOTH,   14'h0ABC, 14'h0ABD, 1'b0, 2'd0);
        add(OP_LOOKUP, 14'h0ABC, 14'h0, 1'b0, 2'd3);
        add(OP_LOOKUP, 14'h0ABD, 14'h0, 1'b0, 2'd2);
        add(OP_BOTH,   14'h1234, 14'h1234, 1'b0, 2'd0);
        add(OP_LOOKUP, 14'h1234, 14'h0, 1'b0, 2'd3);
        add(OP_LKHIT,  14'h0ABD, 14'h0, 1'b0, 2'd2);
        add(OP_LOOKUP, 14'h0ABD, 14'h0, 1'b0, 2'd3);
        add(OP_BOTH,   14'h0055, 14'h0055, 1'b0, 2'd0);
        add(OP_LOOKUP, 14'h0055, 14'h0, 1'b0, 2'd0);

        // Reset defaults
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_valid", 32'(shct_if.lookup_valid_o), 32'd0);
        check("rst_ctr", 32'(shct_if.lookup_ctr_o), 32'd0);
        check("rst_reuse", 32'(shct_if.lookup_reuse_o), 32'd0);
        check("rst_perf_lookup", perf_lookup, 32'd0);
        check("rst_perf_distant", perf_distant, 32'd0);

        // Init sweep length, lookups ignored meanwhile
        rst_n = 1'b1;
        n = 0;
        while (!ready && n < 1000) begin
            if (n == 100) begin
                shct_if.lookup_req_i = 1'b1;
                shct_if.lookup_sig_i = 14'h0123;
            end
            tick();
            n++;
            if (n == 101) begin
                check("lookup_ignored", 32'(shct_if.lookup_valid_o), 32'd0);
                shct_if.lookup_req_i = 1'b0;
            end
        end
        check("init_sweep_edges", 32'(n), 32'd256);

        // Table-driven training/lookup vectors
        foreach (vecs[i]) begin
            idle();
            case (vecs[i].op)
                OP_LOOKUP: lookup(vecs[i].sig_a, vecs[i].exp_ctr);
                OP_HIT:    hit(vecs[i].sig_a);
                OP_EVICT:  evict(vecs[i].sig_a, vecs[i].reused);
                OP_BOTH: begin
                    hit(vecs[i].sig_a);
                    evict(vecs[i].sig_b, vecs[i].reused);
                end
                OP_LKHIT: begin
                    lookup(vecs[i].sig_a, vecs[i].exp_ctr);
                    hit(vecs[i].sig_a);
                end
                default: ;
            endcase
            tick();
        end
        idle();
        tick();
        check("hold_valid", 32'(shct_if.lookup_valid_o), 32'd0);
        check("hold_ctr", 32'(shct_if.lookup_ctr_o), 32'(last_exp));

        // Flush from READY after 0x0055 trained to 0
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready_drop", 32'(ready), 32'd0);
        wait_ready(n);
        check("flush_sweep_cycles", 32'(n), 32'd256);
        lookup(14'h0055, 2'd3);
        tick();
        idle();

        // Flush restarted at sweep cycle 100
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (99) tick();
        check("mid_sweep_ready", 32'(ready), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_ready(n);
        check("restart_sweep_cycles", 32'(n), 32'd256);

        // Async reset mid-sweep
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (20) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready", 32'(ready), 32'd0);
        #1 rst_n = 1'b1;
        wait_ready(n);
        check("async_rst_sweep", 32'(n), 32'd256);

        // Async reset in READY
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready2", 32'(ready), 32'd0);
        #1 rst_n = 1'b1;
        wait_ready(n);
        check("async_rst_sweep2", 32'(n), 32'd256);

        // Performance counters: 10 lookups, 4 to a signature trained to 0
        repeat (3) begin
            idle();
            evict(14'h0077, 1'b0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i % 3 == 0) lookup(14'h0077, 2'd0);
            else            lookup(14'(14'h0100 + i), 2'd3);
            tick();
        end
        idle();
        tick();
`ifdef WT_DCACHE_SHCT_PERF_CNT_EN
        check("perf_lookup", perf_lookup, 32'd10);
        check("perf_distant", perf_distant, 32'd4);
`else
        check("perf_lookup_off", perf_lookup, 32'd0);
        check("perf_distant_off", perf_distant, 32'd0);
`endif
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wt_dcache_shct_predictor.md
Name: wt_dcache_shct_predictor

Overview:
Parametrised signature history counter table (SHCT) for write-through L1 dcache reuse prediction, SHiP-style. Holds 2^SIG_WIDTH saturating counters, indexed by line signature. It has a registered lookup port for fill-time insertion decisions, plus independent hit-train and eviction-train update ports. Reset and flush do not clear the whole array in one cycle; instead an init/flush sweep FSM rewrites SWEEP_PER_CYCLE entries per cycle, which bounds reset fan-out.

Parameters:
SIG_WIDTH, 14, signature width; table depth DEPTH = 2^SIG_WIDTH
CTR_WIDTH, 2, counter width; CTR_MAX = 2^CTR_WIDTH-1
INIT_VAL, CTR_MAX, value written by the sweep; must be <= CTR_MAX
SWEEP_PER_CYCLE, 64, entries rewritten per sweep cycle; power of 2, divides DEPTH

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  start/restart table sweep to INIT_VAL
ready_o  out  1  table initialised; lookups/updates accepted
lookup_req_i  in  1  prediction request
lookup_sig_i  in  SIG_WIDTH  signature to predict
lookup_valid_o  out  1  result valid, one cycle after accepted request
lookup_ctr_o  out  CTR_WIDTH  counter value read
lookup_reuse_o  out  1  1 = predicted reuse (ctr != 0), 0 = distant
hit_i  in  1  cache hit train event
hit_sig_i  in  SIG_WIDTH  signature of hit line
evict_i  in  1  eviction train event
evict_sig_i  in  SIG_WIDTH  signature of evicted line
evict_reused_i  in  1  evicted line was hit at least once while resident
perf_lookup_o  out  32  accepted lookups (optional feature)
perf_distant_o  out  32  lookups predicted distant (optional feature)

Behaviour:
- Reset: state=INIT, sweep ptr=0. ready_o=0, lookup_valid_o=0, lookup_ctr_o=0, lookup_reuse_o=0, perf_*=0. The counter array has no reset; only the sweep writes it.
- States: INIT, READY, FLUSH.
- INIT/FLUSH: each cycle write INIT_VAL to entries ptr*S .. ptr*S+S-1 (S = SWEEP_PER_CYCLE), then ptr++. When the last chunk is written (ptr = DEPTH/S-1), the next state is READY and ptr=0.
- Sweep length: ready_o is registered as (state==READY). It asserts exactly DEPTH/S rising edges after the first edge with rst_ni high (256 at defaults).
- READY + flush_i -> FLUSH with ptr=0, and ready_o drops on the next edge. flush_i during INIT/FLUSH restarts ptr=0.
- Async reset mid-sweep or in READY: immediately INIT, ptr=0.
- While ready_o=0: lookups are ignored (lookup_valid_o stays 0) and hit/evict events are dropped.
- Lookup, 1-cycle latency, no stall: a request accepted at edge N produces lookup_valid_o=1 in cycle N+1 with the registered counter.
  - Read-old semantics: the result reflects the table before updates applied at the same edge.
  - lookup_ctr_o/lookup_reuse_o hold their last value when lookup_valid_o=0.
- Hit update: entry = min(entry+1, CTR_MAX).
- Evict update with evict_reused_i=0: entry = max(entry-1, 0). With evict_reused_i=1: no change.
- Simultaneous hit and decrementing evict on the same signature: entry unchanged (increment and decrement cancel, even at saturation). Different signatures: both applied.
- flush_i has priority over same-cycle updates; those updates are dropped.
- Arithmetic uses CTR_WIDTH-bit values with explicit saturation compares; there is no wrap-around.

Optional Feature:
Macro WT_DCACHE_SHCT_PERF_CNT_EN.
- Defined: perf_lookup_o increments on every accepted lookup. perf_distant_o increments when the returned counter is 0.
  - Both counters are 32-bit and saturate at 2^32-1.
  - Both clear on reset and on flush entry; they are not cleared in INIT.
  - Both update on the edge where lookup_valid_o rises for that request.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset release, defaults -> ready_o=0 for 255 edges and 1 on edge 256; lookups in between give lookup_valid_o=0; first lookup of any signature returns ctr=3, reuse=1.
- Three evicts of sig 0x0055 with reused=0, then a lookup -> ctr=0, reuse=0; a fourth evict then a lookup -> still 0 (floor).
- Hit of sig 0x1234 at ctr=3 -> stays 3. After evict-dec to 2, one hit -> 3.
- Same-cycle hit and evict (reused=0) on sig 0x0ABC at ctr=2 -> 2. With the evict on 0x0ABD instead -> 0x0ABC=3, 0x0ABD=2.
- flush_i in READY after training sig 0x0055 to 0 -> ready_o low for 256 cycles, then 0x0055 reads 3. flush_i at sweep cycle 100 -> sweep restarts; ready_o returns 256 cycles after the second flush.
- Macro defined: 10 lookups, 4 of them to a sig trained to 0 -> perf_lookup_o=10, perf_distant_o=4. Macro undefined -> both 0.
